// File: rtl/debounce_multi.sv
// Multi-channel debouncer: 2-FF sync, per-channel stability counter, edge strobes.
// Define DEBOUNCE_HOLD_EN to add per-channel long-press (hold) detection.
module debounce_multi #(
  parameter int   CHANNELS      = 4,
  parameter int   CNT_W         = 16,
  parameter int   STABLE_CYCLES = 50000,
  parameter logic RESET_LEVEL   = 1'b0,
  parameter int   HOLD_CYCLES   = 1000000
) (
  input  logic                msclk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] btn,
  output logic [CHANNELS-1:0] clean,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic                any_evt,
  output logic [CHANNELS-1:0] hold
);

  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CHANNELS-1:0] RST_VEC =
    {CHANNELS{RESET_LEVEL}};

  logic [CHANNELS-1:0] s1;
  logic [CHANNELS-1:0] s2;
  logic [CHANNELS-1:0] acc;

  always_ff @(posedge msclk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= RST_VEC;
      s2 <= RST_VEC;
    end else begin
      s1 <= btn;
      s2 <= s1;
    end
  end

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    logic [CNT_W-1:0] cnt;
    logic             diff;

    assign diff    = s2[gi] ^ clean[gi];
    assign acc[gi] = diff && (cnt == CNT_MAX);

    // Any agreeing cycle restarts the run; acceptance also restarts it.
    always_ff @(posedge msclk or negedge rst_n) begin
      if (!rst_n) begin
        cnt <= '0;
      end else if (!diff || acc[gi]) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge msclk or negedge rst_n) begin
    if (!rst_n) begin
      clean   <= RST_VEC;
      rise    <= '0;
      fall    <= '0;
      any_evt <= 1'b0;
    end else begin
      clean   <= clean ^ acc;
      rise    <= acc & s2;
      fall    <= acc & ~s2;
      any_evt <= |acc;
    end
  end

`ifdef DEBOUNCE_HOLD_EN
  localparam logic [31:0] HOLD_MAX = 32'(HOLD_CYCLES);

  logic [CHANNELS-1:0] hit;

  for (genvar gh = 0; gh < CHANNELS; gh++) begin : g_hold
    logic [31:0] hcnt;

    assign hit[gh] = clean[gh] && (hcnt == HOLD_MAX - 32'd1);

    // Saturating at HOLD_MAX keeps the strobe to one per press.
    always_ff @(posedge msclk or negedge rst_n) begin
      if (!rst_n) begin
        hcnt <= '0;
      end else if (!clean[gh]) begin
        hcnt <= '0;
      end else if (hcnt != HOLD_MAX) begin
        hcnt <= hcnt + 32'd1;
      end
    end
  end

  always_ff @(posedge msclk or negedge rst_n) begin
    if (!rst_n) begin
      hold <= '0;
    end else begin
      hold <= hit;
    end
  end
`else
  logic unused_hold_cfg;

  assign unused_hold_cfg = ^HOLD_CYCLES;
  assign hold = '0;
`endif

endmodule
